capture_ctrl: RTL

Sequencer for the sample RAMqueue write side of the logic analyzer. It paces RAMqueue writes from the decimated sample strobe and keeps a circular pre-trigger history. Once a trigger is accepted, it counts exactly `trig_pos` post-trigger samples, then pulses `set_capture_done` to cmd_cfg and reports the oldest-sample address for readback. It sits between the trigger logic/decimator and the five channel RAMqueues, which share one write enable and write address.

---
 rtl/la_pkg.sv | 15 +
 rtl/wrap_addr_cnt.sv | 26 ++
 rtl/capture_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/la_pkg.sv
// Shared logic-analyzer definitions: RAMqueue geometry
// and the capture sequencer state encoding.
package la_pkg;

    localparam int ENTRIES = 384;
    localparam int LOG2    = 9;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        POST,
        DONE
    } cap_state_t;

endpackage

// File: rtl/wrap_addr_cnt.sv
// LOG2-bit address counter that wraps from ENTRIES-1 to 0.
// Ports: clk, rst (async high), clr (sync), inc, q.
module wrap_addr_cnt #(
    parameter int ENTRIES = la_pkg::ENTRIES,
    parameter int LOG2    = la_pkg::LOG2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            inc,
    output logic [LOG2-1:0] q
);

    localparam logic [LOG2-1:0] TOP = LOG2'(ENTRIES - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= (q == TOP) ? '0 : q + LOG2'(1);
        end
    end

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer: paces RAMqueue writes, keeps pre-trigger
// history, counts trig_pos post-trigger samples, reports rd_start.
// Ports: clk, rst, run, triggered, wrt_smpl, trig_pos in;
//        we, waddr, armed, capturing, set_capture_done, rd_start out.
module capture_ctrl #(
    parameter int ENTRIES = la_pkg::ENTRIES,
    parameter int LOG2    = la_pkg::LOG2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            triggered,
    input  logic            wrt_smpl,
    input  logic [LOG2-1:0] trig_pos,
    output logic            we,
    output logic [LOG2-1:0] waddr,
    output logic            armed,
    output logic            capturing,
    output logic            set_capture_done,
    output logic [LOG2-1:0] rd_start
);

    import la_pkg::*;

    localparam int              CW    = LOG2 + 1;
    localparam logic [CW-1:0]   ENT_C = CW'(ENTRIES);
    localparam logic [LOG2-1:0] TOP   = LOG2'(ENTRIES - 1);

    cap_state_t      state;
    cap_state_t      nxt;
    logic [CW-1:0]   smpl_cnt;
    logic [LOG2-1:0] trig_cnt;
    logic [LOG2-1:0] trig_hold;
    logic [LOG2-1:0] tp_eff;
    logic            post_end;
    logic            wr_pre;
    logic            wr_post;
    logic            clr;

    assign tp_eff   = (trig_pos > TOP) ? TOP : trig_pos;
    assign post_end = (state == POST) && (trig_cnt == trig_hold);
    assign wr_pre   = (state == ARMED) && wrt_smpl;
    assign wr_post  = (state == POST) && !post_end && wrt_smpl;

    // Clearing on the way into IDLE makes waddr read 0 on the
    // first IDLE cycle after an abort or a finished capture.
    assign clr = (state == IDLE) || (nxt == IDLE);

    always_comb begin
        nxt              = state;
        we               = 1'b0;
        armed            = 1'b0;
        capturing        = 1'b0;
        set_capture_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (run) nxt = ARMED;
            end
            ARMED: begin
                capturing = 1'b1;
                we        = wr_pre;
                armed     = (smpl_cnt + CW'(tp_eff)) >= ENT_C;
                if (!run)
                    nxt = IDLE;
                else if (triggered && armed)
                    nxt = POST;
            end
            POST: begin
                capturing = 1'b1;
                we        = wr_post;
                // abort wins over completion: no pulse when run drops
                if (!run) begin
                    nxt = IDLE;
                end else if (post_end) begin
                    nxt              = DONE;
                    set_capture_done = 1'b1;
                end
            end
            DONE: begin
                if (!run) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            smpl_cnt  <= '0;
            trig_cnt  <= '0;
            trig_hold <= '0;
            rd_start  <= '0;
        end else begin
            state <= nxt;
            if (clr)
                smpl_cnt <= '0;
            else if (wr_pre && smpl_cnt != ENT_C)
                smpl_cnt <= smpl_cnt + CW'(1);
            if (clr)
                trig_cnt <= '0;
            else if (wr_post)
                trig_cnt <= trig_cnt + LOG2'(1);
            if (state == ARMED && nxt == POST)
                trig_hold <= tp_eff;
            if (set_capture_done)
                rd_start <= waddr;
        end
    end

    wrap_addr_cnt #(
        .ENTRIES (ENTRIES),
        .LOG2    (LOG2)
    ) u_waddr (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (we),
        .q   (waddr)
    );

endmodule
